fpu_round_pack: RTL and testbench

//  Rounding/packing stage directly downstream of the exponent adjust stage. Takes the

---
 rtl/fpu_round_pack_if.sv | 32 +++
 rtl/fpu_round_pack.sv | 149 ++++++++++++++
 tb/tb_fpu_round_pack.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_round_pack_if.sv
// Valid/ready bundle between the exponent adjust stage, the round/pack stage and the
// result consumer.
interface fpu_round_pack_if #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_sign;
  logic [EXP_W-1:0]        in_exp;
  logic                    in_exp_neg;
  logic [FRAC_W:0]         in_mant;
  logic [2:0]              in_grs;
  logic [1:0]              in_special;
  logic [1:0]              rnd_mode;
  logic                    out_valid;
  logic                    out_ready;
  logic [EXP_W+FRAC_W:0]   out_result;
  logic [2:0]              out_flags;

  modport master (
    output in_valid, in_sign, in_exp, in_exp_neg, in_mant, in_grs, in_special, rnd_mode,
    output out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_exp_neg, in_mant, in_grs, in_special, rnd_mode,
    input  out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/fpu_round_pack.sv
// IEEE-754 round and pack stage: stage 1 adds the rounding increment, stage 2 renormalises
// and resolves specials, underflow (flush to zero) and overflow into the packed result.
module fpu_round_pack #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23
) (
  input logic             clk,
  input logic             rst_n,
  fpu_round_pack_if.slave bus_io
);
  localparam int unsigned ResW = 1 + EXP_W + FRAC_W;

  typedef enum logic [1:0] {RndRne = 2'b00, RndRtz = 2'b01, RndRup = 2'b10, RndRdn = 2'b11}
    rnd_e;
  typedef enum logic [1:0] {SpNormal = 2'b00, SpZero = 2'b01, SpInf = 2'b10, SpNan = 2'b11}
    special_e;

  localparam logic [EXP_W-1:0]  ExpOnes  = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0]  ExpMax   = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [FRAC_W-1:0] FracOnes = {FRAC_W{1'b1}};
  localparam logic [FRAC_W-1:0] QnanFrac = {1'b1, {(FRAC_W-1){1'b0}}};

  // Handshake
  logic s1_valid_q, s2_valid_q;
  logic s1_load, s2_load, in_fire;

  assign s2_load         = !s2_valid_q || bus_io.out_ready;
  assign s1_load         = !s1_valid_q || s2_load;
  assign in_fire         = bus_io.in_valid && s1_load;
  assign bus_io.in_ready = s1_load;

  // Stage 1: rounding increment
  logic                inc;
  logic                rnd_x;
  logic [FRAC_W+1:0]   mant_r_d;
  rnd_e                rnd_in;

  assign rnd_in = rnd_e'(bus_io.rnd_mode);
  assign rnd_x  = |bus_io.in_grs;

  always_comb begin
    inc = 1'b0;
    unique case (rnd_in)
      RndRne: inc = bus_io.in_grs[2] & (bus_io.in_grs[1] | bus_io.in_grs[0] | bus_io.in_mant[0]);
      RndRtz: inc = 1'b0;
      RndRup: inc = !bus_io.in_sign & rnd_x;
      RndRdn: inc = bus_io.in_sign & rnd_x;
    endcase
    mant_r_d = {1'b0, bus_io.in_mant} + {{(FRAC_W+1){1'b0}}, inc};
  end

  logic              s1_sign_q;
  logic [EXP_W-1:0]  s1_exp_q;
  logic              s1_exp_neg_q;
  special_e          s1_special_q;
  rnd_e              s1_rnd_q;
  logic [FRAC_W+1:0] s1_mant_r_q;
  logic              s1_nx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_exp_q     <= '0;
      s1_exp_neg_q <= 1'b0;
      s1_special_q <= SpNormal;
      s1_rnd_q     <= RndRne;
      s1_mant_r_q  <= '0;
      s1_nx_q      <= 1'b0;
    end else begin
      if (s1_load) s1_valid_q <= bus_io.in_valid;
      if (in_fire) begin
        s1_sign_q    <= bus_io.in_sign;
        s1_exp_q     <= bus_io.in_exp;
        s1_exp_neg_q <= bus_io.in_exp_neg;
        s1_special_q <= special_e'(bus_io.in_special);
        s1_rnd_q     <= rnd_in;
        s1_mant_r_q  <= mant_r_d;
        s1_nx_q      <= rnd_x;
      end
    end
  end

  // Stage 2: renormalise, classify, pack
  logic              carry;
  logic [FRAC_W-1:0] frac;
  logic [EXP_W:0]    exp_r;
  logic              ovf, unf, to_inf;
  logic [ResW-1:0]   result_d;
  logic [2:0]        flags_d;

  always_comb begin
    carry = s1_mant_r_q[FRAC_W+1];
    frac  = carry ? s1_mant_r_q[FRAC_W:1] : s1_mant_r_q[FRAC_W-1:0];
    // One extra bit so a carry out of the top exponent cannot wrap past the compare.
    exp_r = {1'b0, s1_exp_q} + {{EXP_W{1'b0}}, carry};
    ovf   = exp_r >= {1'b0, ExpOnes};
    unf   = s1_exp_neg_q || (s1_exp_q == '0);

    to_inf = 1'b1;
    unique case (s1_rnd_q)
      RndRne: to_inf = 1'b1;
      RndRtz: to_inf = 1'b0;
      RndRup: to_inf = !s1_sign_q;
      RndRdn: to_inf = s1_sign_q;
    endcase

    result_d = {s1_sign_q, exp_r[EXP_W-1:0], frac};
    flags_d  = {2'b00, s1_nx_q};
    if (s1_special_q == SpNan) begin
      result_d = {1'b0, ExpOnes, QnanFrac};
      flags_d  = 3'b000;
    end else if (s1_special_q == SpInf) begin
      result_d = {s1_sign_q, ExpOnes, {FRAC_W{1'b0}}};
      flags_d  = 3'b000;
    end else if (s1_special_q == SpZero) begin
      result_d = {s1_sign_q, {(EXP_W+FRAC_W){1'b0}}};
      flags_d  = 3'b000;
    end else if (unf) begin
      result_d = {s1_sign_q, {(EXP_W+FRAC_W){1'b0}}};
      flags_d  = 3'b011;
    end else if (ovf) begin
      result_d = to_inf ? {s1_sign_q, ExpOnes, {FRAC_W{1'b0}}}
                        : {s1_sign_q, ExpMax, FracOnes};
      flags_d  = 3'b101;
    end
  end

  logic [ResW-1:0] out_result_q;
  logic [2:0]      out_flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q   <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_result_q <= result_d;
        out_flags_q  <= flags_d;
      end
    end
  end

  assign bus_io.out_valid  = s2_valid_q;
  assign bus_io.out_result = out_result_q;
  assign bus_io.out_flags  = out_flags_q;
endmodule

// File: tb/tb_fpu_round_pack.sv
// Directed bench for fpu_round_pack: rounding modes, carry, overflow, underflow, specials,
// backpressure and mid-stream reset.
module tb_fpu_round_pack;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fpu_round_pack_if #(.EXP_W(8), .FRAC_W(23)) bif ();

  fpu_round_pack #(.EXP_W(8), .FRAC_W(23)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bif)
  );

  task automatic drive_fields(input logic sign, input logic [7:0] e, input logic en,
                              input logic [23:0] m, input logic [2:0] grs,
                              input logic [1:0] sp, input logic [1:0] rm);
    bif.in_sign    = sign;
    bif.in_exp     = e;
    bif.in_exp_neg = en;
    bif.in_mant    = m;
    bif.in_grs     = grs;
    bif.in_special = sp;
    bif.rnd_mode   = rm;
  endtask

  // One beat through an idle pipe; returns the result and the accept-to-valid latency.
  task automatic send_one(input logic sign, input logic [7:0] e, input logic en,
                          input logic [23:0] m, input logic [2:0] grs, input logic [1:0] sp,
                          input logic [1:0] rm, output logic [31:0] res,
                          output logic [2:0] flg, output int lat);
    @(negedge clk);
    drive_fields(sign, e, en, m, grs, sp, rm);
    bif.out_ready = 1'b1;
    bif.in_valid  = 1'b1;
    @(posedge clk);
    #1 bif.in_valid = 1'b0;
    lat = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bif.out_valid) break;
      @(posedge clk);
      lat++;
    end
    if (!bif.out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout got=0 want=1");
    end
    res = bif.out_result;
    flg = bif.out_flags;
  endtask

  task automatic test_reset;
    bif.in_valid = 1'b0;
    bif.out_ready = 1'b1;
    drive_fields(1'b0, 8'h00, 1'b0, 24'h0, 3'b000, 2'b00, 2'b00);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bif.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got=%b want=0", bif.out_valid);
    end
    checks++;
    if (bif.out_result !== 32'h0) begin
      errors++; $display("FAIL reset_out_result got=%h want=00000000", bif.out_result);
    end
    checks++;
    if (bif.out_flags !== 3'b000) begin
      errors++; $display("FAIL reset_out_flags got=%b want=000", bif.out_flags);
    end
    checks++;
    if (bif.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got=%b want=1", bif.in_ready);
    end
  endtask

  task automatic test_rne;
    logic [31:0] r;
    logic [2:0]  f;
    int          l;
    send_one(1'b0, 8'h7F, 1'b0, 24'h800001, 3'b100, 2'b00, 2'b00, r, f, l);
    checks++;
    if (r !== 32'h3F800002) begin errors++; $display("FAIL rne_tie_odd got=%h want=3F800002", r); end
    checks++;
    if (f !== 3'b001) begin errors++; $display("FAIL rne_tie_odd_flags got=%b want=001", f); end
    checks++;
    if (l !== 2) begin errors++; $display("FAIL latency got=%0d want=2", l); end
    send_one(1'b0, 8'h7F, 1'b0, 24'h800002, 3'b100, 2'b00, 2'b00, r, f, l);
    checks++;
    if (r !== 32'h3F800002) begin errors++; $display("FAIL rne_tie_even got=%h want=3F800002", r); end
    checks++;
    if (f !== 3'b001) begin errors++; $display("FAIL rne_tie_even_flags got=%b want=001", f); end
    send_one(1'b0, 8'h7F, 1'b0, 24'h800002, 3'b000, 2'b00, 2'b00, r, f, l);
    checks++;
    if (r !== 32'h3F800002) begin errors++; $display("FAIL rne_exact got=%h want=3F800002", r); end
    checks++;
    if (f !== 3'b000) begin errors++; $display("FAIL rne_exact_flags got=%b want=000", f); end
  endtask

  task automatic test_carry;
    logic [31:0] r;
    logic [2:0]  f;
    int          l;
    send_one(1'b0, 8'h7F, 1'b0, 24'hFFFFFF, 3'b100, 2'b00, 2'b00, r, f, l);
    checks++;
    if (r !== 32'h40000000) begin errors++; $display("FAIL carry got=%h want=40000000", r); end
    checks++;
    if (f !== 3'b001) begin errors++; $display("FAIL carry_flags got=%b want=001", f); end
  endtask

  task automatic test_overflow;
    logic [31:0] r;
    logic [2:0]  f;
    int          l;
    // Rounding carry pushes 0xFE into the all-ones exponent
    send_one(1'b0, 8'hFE, 1'b0, 24'hFFFFFF, 3'b110, 2'b00, 2'b00, r, f, l);
    checks++;
    if (r !== 32'h7F800000) begin errors++; $display("FAIL ovf_rne got=%h want=7F800000", r); end
    checks++;
    if (f !== 3'b101) begin errors++; $display("FAIL ovf_rne_flags got=%b want=101", f); end
    send_one(1'b0, 8'hFE, 1'b0, 24'hFFFFFF, 3'b110, 2'b00, 2'b01, r, f, l);
    checks++;
    if (r !== 32'h7F7FFFFF) begin errors++; $display("FAIL rtz_max got=%h want=7F7FFFFF", r); end
    checks++;
    if (f !== 3'b001) begin errors++; $display("FAIL rtz_max_flags got=%b want=001", f); end
    // Negative RUP rounds toward zero, so no increment and no overflow
    send_one(1'b1, 8'hFE, 1'b0, 24'hFFFFFF, 3'b110, 2'b00, 2'b10, r, f, l);
    checks++;
    if (r !== 32'hFF7FFFFF) begin errors++; $display("FAIL rup_neg got=%h want=FF7FFFFF", r); end
    checks++;
    if (f !== 3'b001) begin errors++; $display("FAIL rup_neg_flags got=%b want=001", f); end
    send_one(1'b1, 8'hFF, 1'b0, 24'h800000, 3'b000, 2'b00, 2'b10, r, f, l);
    checks++;
    if (r !== 32'hFF7FFFFF) begin errors++; $display("FAIL ovf_rup_neg got=%h want=FF7FFFFF", r); end
    checks++;
    if (f !== 3'b101) begin errors++; $display("FAIL ovf_rup_neg_flags got=%b want=101", f); end
    send_one(1'b0, 8'hFF, 1'b0, 24'h800000, 3'b000, 2'b00, 2'b11, r, f, l);
    checks++;
    if (r !== 32'h7F7FFFFF) begin errors++; $display("FAIL ovf_rdn_pos got=%h want=7F7FFFFF", r); end
    checks++;
    if (f !== 3'b101) begin errors++; $display("FAIL ovf_rdn_pos_flags got=%b want=101", f); end
    send_one(1'b1, 8'hFF, 1'b0, 24'h800000, 3'b000, 2'b00, 2'b11, r, f, l);
    checks++;
    if (r !== 32'hFF800000) begin errors++; $display("FAIL ovf_rdn_neg got=%h want=FF800000", r); end
  endtask

  task automatic test_underflow_special;
    logic [31:0] r;
    logic [2:0]  f;
    int          l;
    send_one(1'b1, 8'h05, 1'b1, 24'hC00000, 3'b000, 2'b00, 2'b00, r, f, l);
    checks++;
    if (r !== 32'h80000000) begin errors++; $display("FAIL unf_neg got=%h want=80000000", r); end
    checks++;
    if (f !== 3'b011) begin errors++; $display("FAIL unf_neg_flags got=%b want=011", f); end
    send_one(1'b0, 8'h00, 1'b0, 24'hC00000, 3'b000, 2'b00, 2'b00, r, f, l);
    checks++;
    if (r !== 32'h00000000) begin errors++; $display("FAIL unf_exp0 got=%h want=00000000", r); end
    send_one(1'b1, 8'h7F, 1'b0, 24'h812345, 3'b111, 2'b11, 2'b00, r, f, l);
    checks++;
    if (r !== 32'h7FC00000) begin errors++; $display("FAIL nan got=%h want=7FC00000", r); end
    checks++;
    if (f !== 3'b000) begin errors++; $display("FAIL nan_flags got=%b want=000", f); end
    send_one(1'b1, 8'h7F, 1'b0, 24'h812345, 3'b111, 2'b10, 2'b00, r, f, l);
    checks++;
    if (r !== 32'hFF800000) begin errors++; $display("FAIL inf got=%h want=FF800000", r); end
    checks++;
    if (f !== 3'b000) begin errors++; $display("FAIL inf_flags got=%b want=000", f); end
    send_one(1'b1, 8'h7F, 1'b0, 24'h812345, 3'b111, 2'b01, 2'b00, r, f, l);
    checks++;
    if (r !== 32'h80000000) begin errors++; $display("FAIL zero got=%h want=80000000", r); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rx[$];
    logic [31:0] hold_res;
    int          sent  = 0;
    int          stall = 0;
    bit          first = 1'b0;
    bit          hold  = 1'b0;
    bit          saw_block = 1'b0;
    bit          in_acc;
    drive_fields(1'b0, 8'h7F, 1'b0, 24'h800001, 3'b000, 2'b00, 2'b01);
    for (int cyc = 0; cyc < 60 && rx.size() < 6; cyc++) begin
      @(negedge clk);
      bif.out_ready = (stall == 0);
      if (stall > 0) stall--;
      bif.in_valid = (sent < 6);
      bif.in_mant  = 24'h800001 + 24'(sent);
      #1;
      if (hold) begin
        checks++;
        if (bif.out_valid !== 1'b1 || bif.out_result !== hold_res) begin
          errors++;
          $display("FAIL hold_stable got=%b/%h want=1/%h", bif.out_valid, bif.out_result,
                   hold_res);
        end
      end
      if (bif.in_valid && !bif.in_ready) saw_block = 1'b1;
      in_acc = bif.in_valid && bif.in_ready;
      if (bif.out_valid && bif.out_ready) begin
        rx.push_back(bif.out_result);
        if (!first) begin
          first = 1'b1;
          stall = 3;
        end
      end
      hold     = bif.out_valid && !bif.out_ready;
      hold_res = bif.out_result;
      @(posedge clk);
      if (in_acc) sent++;
    end
    @(negedge clk);
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b1;
    checks++;
    if (rx.size() !== 6) begin errors++; $display("FAIL stream_count got=%0d want=6", rx.size()); end
    for (int i = 0; i < rx.size(); i++) begin
      checks++;
      if (rx[i] !== 32'h3F800000 + 32'(i + 1)) begin
        errors++;
        $display("FAIL stream_beat%0d got=%h want=%h", i, rx[i], 32'h3F800000 + 32'(i + 1));
      end
    end
    checks++;
    if (saw_block !== 1'b1) begin errors++; $display("FAIL in_ready_drop got=0 want=1"); end
    repeat (2) @(negedge clk);
    checks++;
    if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL stream_extra got=1 want=0"); end
  endtask

  task automatic test_reset_midstream;
    logic [31:0] r;
    logic [2:0]  f;
    int          l;
    bit          seen = 1'b0;
    @(negedge clk);
    drive_fields(1'b0, 8'h7F, 1'b0, 24'h800005, 3'b000, 2'b00, 2'b01);
    bif.out_ready = 1'b1;
    bif.in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bif.in_mant = 24'h800006;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bif.out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got=0 want=1"); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bif.out_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset_valid got=%b want=0", bif.out_valid);
    end
    bif.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bif.out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL stale_after_reset got=1 want=0"); end
    send_one(1'b0, 8'h80, 1'b0, 24'h800007, 3'b000, 2'b00, 2'b01, r, f, l);
    checks++;
    if (r !== 32'h40000007) begin errors++; $display("FAIL post_reset got=%h want=40000007", r); end
  endtask

  initial begin
    test_reset();
    test_rne();
    test_carry();
    test_overflow();
    test_underflow_special();
    test_back_to_back();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
